// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// access-size masks and request-classification helpers.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_HI   = 2'd2,
      ST_WR_HI   = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   function automatic logic [3:0] size_mask(input logic [1:0] size);
      logic [3:0] m;
      case (size)
         2'b00:   m = MASK_B;
         2'b01:   m = MASK_H;
         default: m = MASK_W;
      endcase
      return m;
   endfunction

   // Stores have no unsigned variants, so LBU/LHU codes are only legal for loads.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// load_extender: picks the addressed bytes out of a {hi,lo} word pair and
// sign- or zero-extends them according to the load funct3.
module load_extender
   import load_store_unit_pkg::*;
(
   input  logic [63:0] pair,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [31:0] lane_s;

   assign lane_s = 32'(pair >> {offset, 3'b000});

   // Extension by access size and signedness.
   always_comb begin
      rdata = 32'h0000_0000;
      case (funct3)
         F3_B:    rdata = {{24{lane_s[7]}}, lane_s[7:0]};
         F3_H:    rdata = {{16{lane_s[15]}}, lane_s[15:0]};
         F3_W:    rdata = lane_s;
         F3_BU:   rdata = {24'h00_0000, lane_s[7:0]};
         F3_HU:   rdata = {16'h0000, lane_s[15:0]};
         default: rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer for a single-port memory with one-cycle read latency.
// Define MISALIGNED_SPLIT_EN to split misaligned accesses into two word accesses instead of rejecting them.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [31:0]           resp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [3:0]            mem_byteena,
   output logic [31:0]           mem_data,
   output logic                  mem_wren,
   input  logic [31:0]           mem_q
);

`ifdef MISALIGNED_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   lsu_state_t            state_r, state_n;
   logic                  accept_s, legal_s, mis_s;
   logic                  resp_set_s, err_set_s;
   logic [ADDR_WIDTH-1:0] word_addr_s;
   logic [7:0]            be_pair_s;
   logic [63:0]           data_pair_s;
   logic [63:0]           ext_pair_s;
   logic [31:0]           ext_rdata_s;
   logic                  unused_s;

   logic                  resp_valid_r, resp_err_r, split_r;
   logic [1:0]            off_r;
   logic [2:0]            funct3_r;
   logic [ADDR_WIDTH-1:0] hi_addr_r;
   logic [3:0]            be_hi_r;
   logic [31:0]           data_hi_r, lo_r;

   assign unused_s    = ^req_addr[31:ADDR_WIDTH+2];
   assign req_ready   = (state_r == ST_IDLE) && !reset;
   assign accept_s    = req_valid && req_ready;
   assign legal_s     = f3_legal(req_we, req_funct3);
   assign mis_s       = is_misaligned(req_funct3[1:0], req_addr[1:0]);
   assign word_addr_s = req_addr[ADDR_WIDTH+1:2];
   // Upper half of each pair spills into the following word when the access crosses it.
   assign be_pair_s   = {4'b0000, size_mask(req_funct3[1:0])} << req_addr[1:0];
   assign data_pair_s = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};

   assign ext_pair_s  = split_r ? {mem_q, lo_r} : {32'h0000_0000, mem_q};

   load_extender u_load_extender (
      .pair   (ext_pair_s),
      .offset (off_r),
      .funct3 (funct3_r),
      .rdata  (ext_rdata_s)
   );

   assign resp_valid = resp_valid_r || (state_r == ST_RD_WAIT);
   assign resp_err   = resp_err_r;
   assign resp_rdata = (state_r == ST_RD_WAIT) ? ext_rdata_s : 32'h0000_0000;

   // Next-state and memory-port decode.
   always_comb begin
      state_n     = state_r;
      mem_address = word_addr_s;
      mem_byteena = be_pair_s[3:0];
      mem_data    = data_pair_s[31:0];
      mem_wren    = 1'b0;
      resp_set_s  = 1'b0;
      err_set_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!accept_s) begin
               state_n = ST_IDLE;
            end else if (!legal_s || (mis_s && !SPLIT_EN)) begin
               resp_set_s = 1'b1;
               err_set_s  = 1'b1;
            end else if (req_we) begin
               mem_wren = 1'b1;
               if (mis_s) begin
                  state_n = ST_WR_HI;
               end else begin
                  resp_set_s = 1'b1;
               end
            end else begin
               state_n = mis_s ? ST_RD_HI : ST_RD_WAIT;
            end
         end
         ST_RD_HI: begin
            mem_address = hi_addr_r;
            mem_byteena = 4'b1111;
            mem_data    = 32'h0000_0000;
            state_n     = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            mem_address = hi_addr_r;
            mem_byteena = 4'b0000;
            mem_data    = 32'h0000_0000;
            state_n     = ST_IDLE;
         end
         ST_WR_HI: begin
            mem_address = hi_addr_r;
            mem_byteena = be_hi_r;
            mem_data    = data_hi_r;
            mem_wren    = 1'b1;
            resp_set_s  = 1'b1;
            state_n     = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, response flags and the per-request context used after acceptance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         split_r      <= 1'b0;
         off_r        <= 2'b00;
         funct3_r     <= 3'b000;
         hi_addr_r    <= {ADDR_WIDTH{1'b0}};
         be_hi_r      <= 4'b0000;
         data_hi_r    <= 32'h0000_0000;
         lo_r         <= 32'h0000_0000;
      end else begin
         state_r      <= state_n;
         resp_valid_r <= resp_set_s;
         resp_err_r   <= err_set_s;
         if (accept_s) begin
            split_r   <= mis_s;
            off_r     <= req_addr[1:0];
            funct3_r  <= req_funct3;
            hi_addr_r <= word_addr_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            be_hi_r   <= be_pair_s[7:4];
            data_hi_r <= data_pair_s[63:32];
         end
         if (state_r == ST_RD_HI) begin
            lo_r <= mem_q;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// every memory write and every response (value and cycle); monitors pop and compare.
module tb_load_store_unit;

   localparam int AW = 10;

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_address;
   logic [3:0]    mem_byteena;
   logic [31:0]   mem_data;
   logic          mem_wren;
   logic [31:0]   mem_q;

   always #5 clock = ~clock;

   load_store_unit #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
      .mem_wren(mem_wren), .mem_q(mem_q)
   );

   // Data memory: registered address/write, read data one cycle later.
   logic [31:0] mem [0:1023];
   always @(posedge clock) begin
      for (int l = 0; l < 4; l++)
         if (mem_wren && mem_byteena[l]) mem[mem_address][8*l +: 8] <= mem_data[8*l +: 8];
      mem_q <= mem[mem_address];
   end

   logic [7:0] ref_mem [0:4095];

   typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
   typedef struct { logic [9:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
   resp_t rq[$];
   wr_t   wq[$];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int size_bytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit legal(input logic we, input logic [2:0] f3);
      if (we) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
      return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
   endfunction

   // An access is misaligned exactly when its bytes cross into the next word.
   function automatic bit crosses(input logic [2:0] f3, input logic [31:0] a);
      return (int'(a[1:0]) + size_bytes(f3)) > 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int n;
      logic [31:0] v;
      n = size_bytes(f3);
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + 32'(i)) & 32'hFFF];
      if (!f3[2] && n < 4 && v[8*n-1])
         for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   // Drive one request; on acceptance, queue the predicted writes and response.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit aborted);
      bit    err, split, done;
      int    n;
      wr_t   e0, e1;
      logic [31:0] b;
      resp_t r;
      n     = size_bytes(f3);
      err   = !legal(we, f3) || (crosses(f3, addr) && !SPLIT);
      split = !err && crosses(f3, addr);
      done  = 1'b0;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clock);
         if (req_ready) begin
            done = 1'b1;
            if (!err && we) begin
               e0.addr = addr[11:2]; e0.be = 4'h0; e0.data = 32'h0;
               e1.addr = addr[11:2] + 10'd1; e1.be = 4'h0; e1.data = 32'h0;
               for (int i = 0; i < n; i++) begin
                  b = (addr + 32'(i)) & 32'hFFF;
                  if (b[11:2] == e0.addr) begin
                     e0.be[b[1:0]] = 1'b1; e0.data[8*b[1:0] +: 8] = wd[8*i +: 8];
                     ref_mem[b] = wd[8*i +: 8];
                  end else begin
                     e1.be[b[1:0]] = 1'b1; e1.data[8*b[1:0] +: 8] = wd[8*i +: 8];
                     if (!aborted) ref_mem[b] = wd[8*i +: 8];
                  end
               end
               wq.push_back(e0);
               if (split && !aborted) wq.push_back(e1);
            end
            r.err   = err;
            r.rdata = (!err && !we) ? ref_load(f3, addr) : 32'h0;
            r.cyc   = cyc + (split ? 2 : 1);
            if (!aborted) rq.push_back(r);
         end
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      if (!done) chk("accept_timeout", 32'(req_ready), 32'h1);
   endtask

   // Reset in the middle of a two-phase access must kill it silently.
   task automatic abort_test(input logic we, input logic [31:0] addr);
      issue(we, 3'b010, addr, 32'hCAFE_F00D, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_mid_resp_err",   32'(resp_err),   32'h0);
      chk("rst_mid_resp_rdata", resp_rdata,      32'h0);
      chk("rst_mid_mem_wren",   32'(mem_wren),   32'h0);
      chk("rst_mid_req_ready",  32'(req_ready),  32'h0);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // Response and write monitors, sampled mid low phase.
   always @(negedge clock) begin
      resp_t e;
      wr_t   w;
      logic [31:0] m;
      #1;
      if (!reset) begin
         if (resp_valid) begin
            if (rq.size() == 0) begin
               chk("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
               e = rq.pop_front();
               chk("resp_err",   32'(resp_err), 32'(e.err));
               chk("resp_rdata", resp_rdata,    e.rdata);
               chk("resp_cycle", 32'(cyc),      32'(e.cyc));
            end
         end
         if (mem_wren) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 32'(mem_wren), 32'h0);
            end else begin
               w = wq.pop_front();
               m = {{8{w.be[3]}}, {8{w.be[2]}}, {8{w.be[1]}}, {8{w.be[0]}}};
               chk("wr_address", 32'(mem_address), 32'(w.addr));
               chk("wr_byteena", 32'(mem_byteena), 32'(w.be));
               chk("wr_data",    mem_data & m,     w.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom;
         for (int l = 0; l < 4; l++) ref_mem[4*i + l] = mem[i][8*l +: 8];
      end
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_req_ready",  32'(req_ready),  32'h0);
      chk("reset_resp_valid", 32'(resp_valid), 32'h0);
      chk("reset_resp_err",   32'(resp_err),   32'h0);
      chk("reset_mem_wren",   32'(mem_wren),   32'h0);
      reset = 1'b0;
      #1;
      chk("post_reset_ready", 32'(req_ready),  32'h1);
      @(posedge clock); #1;

      issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);

      issue(1'b1, 3'b010, 32'h0000_0000, 32'h80FF_7F01, 1'b0);
      issue(1'b0, 3'b000, 32'h0000_0003, 32'h0, 1'b0);
      issue(1'b0, 3'b100, 32'h0000_0003, 32'h0, 1'b0);
      issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 1'b0);
      issue(1'b0, 3'b101, 32'h0000_0000, 32'h0, 1'b0);

      issue(1'b1, 3'b010, 32'h0000_0020, 32'h0000_0000, 1'b0);
      issue(1'b1, 3'b000, 32'h0000_0021, 32'h0000_00AB, 1'b0);
      issue(1'b1, 3'b001, 32'h0000_0022, 32'h0000_1234, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b0);

      issue(1'b0, 3'b011, 32'h0000_0020, 32'h0, 1'b0);
      issue(1'b1, 3'b100, 32'h0000_0020, 32'h5555_5555, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b0);

      issue(1'b1, 3'b010, 32'h0000_0FFF, 32'h1122_3344, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0FFF, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0FFC, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0);

      abort_test(1'b0, 32'h0000_0FFE);
      issue(1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
      abort_test(1'b1, 32'h0000_0FFD);
      issue(1'b0, 3'b010, 32'h0000_0FFC, 32'h0, 1'b0);
      issue(1'b0, 3'b010, 32'h0000_0000, 32'h0, 1'b0);

      for (int k = 0; k < 300; k++) begin
         a = $urandom;
         a[11:6] = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'h00;
         issue(1'(($urandom_range(0, 2) == 0)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
      end

      repeat (4) @(posedge clock);
      #1;
      chk("resp_queue_drained",  32'(rq.size()), 32'h0);
      chk("write_queue_drained", 32'(wq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
